// File: rtl/teamj_pkg.sv
// teamj_pkg: shared defaults and reset values for the teamj inverter/monitor cell
package teamj_pkg;
    localparam int   SYNC_STAGES_DEF = 2;
    localparam int   CNT_W_DEF       = 8;
    localparam logic SYNC_RST_VAL    = 1'b0;
    localparam int   CNT_RST_VAL     = 0;
endpackage

// File: rtl/teamj_if.sv
// teamj_if: data, clear and monitor-status signals of the teamj cell
interface teamj_if import teamj_pkg::*; #(parameter int CNT_W = CNT_W_DEF) ();
    logic             A0;
    logic             cnt_clr;
    logic             Q0;
    logic             q_reg;
    logic             a_rise;
    logic             a_fall;
    logic [CNT_W-1:0] edge_cnt;
    modport master (output A0, cnt_clr, input Q0, q_reg, a_rise, a_fall, edge_cnt);
    modport slave  (input A0, cnt_clr, output Q0, q_reg, a_rise, a_fall, edge_cnt);
endinterface

// File: rtl/teamj_sync.sv
// teamj_sync: N-flop synchroniser with async active-low reset
module teamj_sync import teamj_pkg::*; #(parameter int N = SYNC_STAGES_DEF) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [N-1:0] s_q, s_d;
    always_comb s_d = {s_q[N-2:0], d};
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) s_q <= {N{SYNC_RST_VAL}};
        else        s_q <= s_d;
    assign q = s_q[N-1];
endmodule

// File: rtl/teamj_design.sv
// teamj_design: combinational inverter plus synchronised edge/transition monitor
module teamj_design import teamj_pkg::*; #(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input logic   clk,
    input logic   rst_n,
    teamj_if.slave bus
);
    logic             a_s;
    logic             a_d_q, a_d_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    teamj_sync #(.N(SYNC_STAGES)) u_sync (.clk(clk), .rst_n(rst_n), .d(bus.A0), .q(a_s));
    always_comb begin
        a_d_d  = a_s;
        rise_d = a_s & ~a_d_q;
        fall_d = ~a_s & a_d_q;
        cnt_d  = bus.cnt_clr ? '0 : ((a_s ^ a_d_q) && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            a_d_q  <= SYNC_RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            cnt_q  <= CNT_W'(CNT_RST_VAL);
        end else begin
            a_d_q  <= a_d_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            cnt_q  <= cnt_d;
        end
    assign bus.Q0       = ~bus.A0;
    assign bus.q_reg    = ~a_s;
    assign bus.a_rise   = rise_q;
    assign bus.a_fall   = fall_q;
    assign bus.edge_cnt = cnt_q;
endmodule

// File: tb/tb_teamj_design.sv
// tb_teamj_design: directed checks of inversion, sync latency, edge pulses, counter clear/saturation and reset
module tb_teamj_design;
    logic clk = 1'b0, clk_en = 1'b0, rst_n = 1'b0, a0 = 1'b0, clr = 1'b0;
    int   n_chk = 0, n_fail = 0, rises, falls;
    teamj_if #(.CNT_W(8)) bus ();
    teamj_if #(.CNT_W(3)) bus3 ();
    assign bus.A0 = a0;
    assign bus.cnt_clr = clr;
    assign bus3.A0 = a0;
    assign bus3.cnt_clr = clr;
    teamj_design #(.SYNC_STAGES(2), .CNT_W(8)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    teamj_design #(.SYNC_STAGES(2), .CNT_W(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
    always #5 if (clk_en) clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        rises += int'(bus.a_rise);
        falls += int'(bus.a_fall);
    endtask
    initial begin
        #500 chk("q0_a0_0", bus.Q0, 1);
        a0 = 1'b1;
        #500 chk("q0_a0_1", bus.Q0, 0);
        chk("rst_q_reg", bus.q_reg, 1);
        chk("rst_rise", bus.a_rise, 0);
        chk("rst_fall", bus.a_fall, 0);
        chk("rst_cnt", bus.edge_cnt, 0);
        clk_en = 1'b1;
        rises = 0;
        falls = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("lat_q_reg_e1", bus.q_reg, 1);
        tick();
        chk("lat_q_reg_e2", bus.q_reg, 0);
        chk("lat_rise_e2", bus.a_rise, 0);
        tick();
        chk("lat_rise_e3", bus.a_rise, 1);
        chk("lat_cnt_e3", bus.edge_cnt, 1);
        tick();
        chk("lat_rise_e4", bus.a_rise, 0);
        chk("lat_cnt_e4", bus.edge_cnt, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_cnt", bus.edge_cnt, 0);
        chk("clr_cnt3", bus3.edge_cnt, 0);
        rises = 0;
        falls = 0;
        for (int i = 0; i < 10; i++) begin
            a0 = ~a0;
            repeat (4) tick();
            if (i == 5) chk("sat_cnt3_6", bus3.edge_cnt, 6);
            if (i == 6) chk("sat_cnt3_7", bus3.edge_cnt, 7);
            if (i == 8) chk("sat_cnt3_9", bus3.edge_cnt, 7);
        end
        chk("train_rises", rises, 5);
        chk("train_falls", falls, 5);
        chk("train_cnt", bus.edge_cnt, 10);
        chk("train_cnt3", bus3.edge_cnt, 7);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        rises = 0;
        falls = 0;
        for (int i = 0; i < 4; i++) begin
            a0 = ~a0;
            tick();
        end
        repeat (4) tick();
        chk("b2b_cnt", bus.edge_cnt, 4);
        chk("b2b_rises", rises, 2);
        chk("b2b_falls", falls, 2);
        a0 = 1'b0;
        repeat (2) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("prio_cnt", bus.edge_cnt, 0);
        chk("prio_fall", bus.a_fall, 1);
        repeat (3) tick();
        chk("prio_cnt_hold", bus.edge_cnt, 0);
        for (int i = 0; i < 5; i++) begin
            a0 = ~a0;
            repeat (i == 4 ? 3 : 4) tick();
        end
        chk("mid_cnt5", bus.edge_cnt, 5);
        chk("mid_rise_pre", bus.a_rise, 1);
        #2 rst_n = 1'b0;
        #1 chk("mid_rst_cnt", bus.edge_cnt, 0);
        chk("mid_rst_rise", bus.a_rise, 0);
        chk("mid_rst_fall", bus.a_fall, 0);
        chk("mid_rst_q_reg", bus.q_reg, 1);
        chk("mid_rst_q0", bus.Q0, 0);
        a0 = 1'b0;
        #1 chk("mid_rst_q0_track", bus.Q0, 1);
        a0 = 1'b1;
        @(negedge clk);
        chk("mid_rst_hold_cnt", bus.edge_cnt, 0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_rise", bus.a_rise, 1);
        chk("post_rst_cnt", bus.edge_cnt, 1);
        chk("post_rst_cnt3", bus3.edge_cnt, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
